cgra_stream_harness: RTL

- Synthesizable, parametrised stream harness for full-system CGRA bring-up.
- Loads a configuration stream into the fabric's config_addr/config_data bus, then drives LANES independent data streams into input pads.
- Checks the returned pad outputs against an expected scaled copy, compensating for a programmable fabric latency.
- Sits between a host/ROM config source and the CGRA top, replacing file-driven bench stimulus with an on-chip equivalent.

---
 rtl/cgra_harness_pkg.sv | 24 ++
 rtl/stream_delay_line.sv | 52 +++++
 rtl/cgra_stream_harness.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cgra_harness_pkg.sv
// rtl/cgra_harness_pkg.sv - shared types, encodings and helpers for the CGRA stream harness
package cgra_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_GAP,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Callers truncate the result to their lane width.
  function automatic logic [63:0] scale_expected(input logic [63:0] stim, input logic [3:0] shift);
    return stim << shift;
  endfunction

endpackage

// File: rtl/stream_delay_line.sv
// rtl/stream_delay_line.sv - MAX_LAT-deep {valid, payload} shift register with runtime tap select
module stream_delay_line #(
  parameter int W       = 32,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             clr_in,
  input  logic             valid_in,
  input  logic [W-1:0]     data_in,
  input  logic [LAT_W-1:0] latency_in,
  output logic             valid_out,
  output logic [W-1:0]     data_out
);

  logic [MAX_LAT-1:0] vld_q;
  logic [W-1:0]       data_q [MAX_LAT];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      vld_q <= '0;
    end else if (clr_in) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_in;
      for (int i = 1; i < MAX_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk_in) begin
    data_q[0] <= data_in;
    for (int i = 1; i < MAX_LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  always_comb begin
    valid_out = 1'b0;
    data_out  = data_q[0];
    for (int i = 0; i < MAX_LAT; i++) begin
      if (latency_in == LAT_W'(i + 1)) begin
        valid_out = vld_q[i];
        data_out  = data_q[i];
      end
    end
  end

endmodule

// File: rtl/cgra_stream_harness.sv
// rtl/cgra_stream_harness.sv - config loader, lane stimulus generator and latency-compensated response checker
import cgra_harness_pkg::*;

module cgra_stream_harness #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 2,
  parameter int CFG_ADDR_W = 32,
  parameter int CFG_DATA_W = 32,
  parameter int MAX_LAT    = 8,
  parameter int CYC_W      = 32
) (
  input  logic                          clk_in,
  input  logic                          reset_n_in,
  input  logic                          start_in,
  input  logic                          mode_in,
  input  logic [3:0]                    shift_in,
  input  logic [$clog2(MAX_LAT+1)-1:0]  latency_in,
  input  logic [CYC_W-1:0]              run_cycles_in,
  input  logic                          cfg_valid_in,
  output logic                          cfg_ready_out,
  input  logic [CFG_ADDR_W-1:0]         cfg_addr_in,
  input  logic [CFG_DATA_W-1:0]         cfg_data_in,
  input  logic                          cfg_last_in,
  output logic [CFG_ADDR_W-1:0]         config_addr_out,
  output logic [CFG_DATA_W-1:0]         config_data_out,
  output logic [LANES*DATA_W-1:0]       stim_out,
  input  logic [LANES*DATA_W-1:0]       resp_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          pass_out,
  output logic [CYC_W-1:0]              err_count_out,
  output logic [CYC_W-1:0]              first_err_cycle_out
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int SW    = LANES * DATA_W;

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic [3:0]              shift_q;
  logic [LAT_W-1:0]        lat_q, lat_clamped;
  logic [CYC_W-1:0]        run_len_q, run_cnt_q;
  logic [LAT_W-1:0]        flush_cnt_q;
  logic [DATA_W-1:0]       base_q;
  logic [DATA_W-1:0]       lfsr_q [LANES];
  logic [SW-1:0]           stim_q, stim_next, exp_vec;
  logic                    stim_vld_q;
  logic [CFG_ADDR_W-1:0]   cfg_addr_q;
  logic [CFG_DATA_W-1:0]   cfg_data_q;
  logic [CYC_W-1:0]        err_q, first_err_q, chk_cnt_q, nmis, err_next;
  logic [CYC_W:0]          err_sum;
  logic                    first_set_q;
  logic                    start_go, cfg_accept;
  logic                    dly_vld;
  logic [SW-1:0]           dly_exp;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] taps;
    taps = DATA_W'(LFSR_TAPS);
    return {s[DATA_W-2:0], ^(s & taps)};
  endfunction

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_in) state_d = ST_CONFIG;
      ST_CONFIG:        if (cfg_valid_in && cfg_last_in) state_d = ST_GAP;
      ST_GAP:           state_d = (run_len_q == '0) ? ST_FLUSH : ST_RUN;
      ST_RUN:           if (run_cnt_q == run_len_q - CYC_W'(1)) state_d = ST_FLUSH;
      ST_FLUSH:         if (flush_cnt_q == lat_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_out = (state_q == ST_CONFIG);
    busy_out      = (state_q == ST_CONFIG) || (state_q == ST_GAP) ||
                    (state_q == ST_RUN)    || (state_q == ST_FLUSH);
    done_out      = (state_q == ST_DONE);
    pass_out      = (state_q == ST_DONE) && (err_q == '0);
  end

  assign start_go   = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cfg_accept = cfg_valid_in && (state_q == ST_CONFIG);

  always_comb begin
    lat_clamped = latency_in;
    if (latency_in == '0)                  lat_clamped = LAT_W'(1);
    else if (latency_in > LAT_W'(MAX_LAT)) lat_clamped = LAT_W'(MAX_LAT);
  end

  always_comb begin
    stim_next = '0;
    exp_vec   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode_q == MODE_LFSR) stim_next[i*DATA_W +: DATA_W] = lfsr_q[i];
      else                     stim_next[i*DATA_W +: DATA_W] = base_q + DATA_W'(i);
      exp_vec[i*DATA_W +: DATA_W] =
        DATA_W'(scale_expected(64'(stim_q[i*DATA_W +: DATA_W]), shift_q));
    end
  end

  // Expected values are derived from the registered pad word, so tap L lines up with a fabric of latency L.
  stream_delay_line #(
    .W       (SW),
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_delay (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .clr_in     (start_go),
    .valid_in   (stim_vld_q),
    .data_in    (exp_vec),
    .latency_in (lat_q),
    .valid_out  (dly_vld),
    .data_out   (dly_exp)
  );

  always_comb begin
    nmis = '0;
    for (int i = 0; i < LANES; i++) begin
      if (dly_vld && (resp_in[i*DATA_W +: DATA_W] != dly_exp[i*DATA_W +: DATA_W])) begin
        nmis = nmis + CYC_W'(1);
      end
    end
    err_sum  = {1'b0, err_q} + {1'b0, nmis};
    err_next = err_sum[CYC_W] ? '1 : err_sum[CYC_W-1:0];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mode_q      <= MODE_INC;
      shift_q     <= '0;
      lat_q       <= LAT_W'(1);
      run_len_q   <= '0;
      run_cnt_q   <= '0;
      flush_cnt_q <= '0;
      base_q      <= '0;
      for (int i = 0; i < LANES; i++) lfsr_q[i] <= DATA_W'(i + 1);
      stim_q      <= '0;
      stim_vld_q  <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      err_q       <= '0;
      first_err_q <= '1;
      first_set_q <= 1'b0;
      chk_cnt_q   <= '0;
    end else begin
      cfg_addr_q <= '0;
      if (cfg_accept) begin
        cfg_addr_q <= cfg_addr_in;
        cfg_data_q <= cfg_data_in;
      end
      if (start_go) begin
        mode_q      <= mode_in;
        shift_q     <= shift_in;
        lat_q       <= lat_clamped;
        run_len_q   <= run_cycles_in;
        run_cnt_q   <= '0;
        flush_cnt_q <= '0;
        base_q      <= '0;
        for (int i = 0; i < LANES; i++) lfsr_q[i] <= DATA_W'(i + 1);
        stim_q      <= '0;
        stim_vld_q  <= 1'b0;
        err_q       <= '0;
        first_err_q <= '1;
        first_set_q <= 1'b0;
        chk_cnt_q   <= '0;
      end else begin
        if (state_q == ST_RUN) begin
          stim_q     <= stim_next;
          stim_vld_q <= 1'b1;
          base_q     <= base_q + DATA_W'(1);
          for (int i = 0; i < LANES; i++) lfsr_q[i] <= lfsr_step(lfsr_q[i]);
          run_cnt_q  <= run_cnt_q + CYC_W'(1);
        end else if (state_q == ST_FLUSH) begin
          stim_vld_q  <= 1'b0;
          flush_cnt_q <= flush_cnt_q + LAT_W'(1);
        end
        if (dly_vld) begin
          chk_cnt_q <= chk_cnt_q + CYC_W'(1);
          if (nmis != '0) begin
            err_q <= err_next;
            if (!first_set_q) begin
              first_err_q <= chk_cnt_q;
              first_set_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign config_addr_out     = cfg_addr_q;
  assign config_data_out     = cfg_data_q;
  assign stim_out            = stim_q;
  assign err_count_out       = err_q;
  assign first_err_cycle_out = first_err_q;

endmodule
